// File: rtl/regfile_alu_engine.sv
// Register-file / ALU execution engine.
// One register-to-register command per handshake: operands are latched on
// accept, the ALU result and flags are registered in EXEC, and the result is
// written back while done pulses in WRITE. A host port preloads registers and
// two combinational debug ports expose register contents.
module regfile_alu_engine #(
   parameter int DATA_W  = 32,
   parameter int NREG    = 32,
   parameter bit ZERO_R0 = 1'b1,
   localparam int ADDR_W = $clog2(NREG)
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_rs1,
   input  logic [ADDR_W-1:0] cmd_rs2,
   input  logic [ADDR_W-1:0] cmd_rd,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wd,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_c,
   output logic              flag_v
);

   localparam int SH_W = $clog2(DATA_W);
   localparam int MSB  = DATA_W - 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_WRITE
   } state_e;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_XOR = 3'b100,
      OP_SLT = 3'b101,
      OP_SLL = 3'b110,
      OP_SRL = 3'b111
   } op_e;

   state_e              state_q;
   op_e                 op_q;
   logic [ADDR_W-1:0]   rd_q;
   logic [DATA_W-1:0]   opa_q;
   logic [DATA_W-1:0]   opb_q;
   logic [DATA_W-1:0]   result_q;
   logic                flag_z_q;
   logic                flag_c_q;
   logic                flag_v_q;
   logic                done_q;
   logic [DATA_W-1:0]   regs_q [NREG];

   logic                accept;
   logic                host_wr;
   logic [DATA_W-1:0]   rs1_data;
   logic [DATA_W-1:0]   rs2_data;
   logic [DATA_W:0]     sum_ext;
   logic [DATA_W:0]     dif_ext;
   logic [DATA_W-1:0]   alu_res;
   logic                alu_c;
   logic                alu_v;

   // The host port only owns the register file while the engine is idle, and
   // a simultaneous host write takes priority over a pending command.
   assign cmd_ready = (state_q == S_IDLE) && !host_we;
   assign accept    = cmd_ready && cmd_valid;
   assign host_wr   = (state_q == S_IDLE) && host_we;

   // r0 is never written when ZERO_R0, so the masks on the read side only
   // make the zero explicit rather than relying on the reset value.
   assign rs1_data = (ZERO_R0 && cmd_rs1 == '0) ? '0 : regs_q[cmd_rs1];
   assign rs2_data = (ZERO_R0 && cmd_rs2 == '0) ? '0 : regs_q[cmd_rs2];
   assign RD1      = (ZERO_R0 && A1 == '0)      ? '0 : regs_q[A1];
   assign RD2      = (ZERO_R0 && A2 == '0)      ? '0 : regs_q[A2];

   // Subtraction is a + ~b + 1 so its carry-out is the not-borrow flag.
   assign sum_ext = {1'b0, opa_q} + {1'b0, opb_q};
   assign dif_ext = {1'b0, opa_q} + {1'b0, ~opb_q} + {{DATA_W{1'b0}}, 1'b1};

   // ALU: result plus carry/overflow for the latched operands.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves a value
      // unassigned, which would otherwise infer a latch.
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op_q)
         OP_ADD: begin
            alu_res = sum_ext[MSB:0];
            alu_c   = sum_ext[DATA_W];
            alu_v   = (opa_q[MSB] == opb_q[MSB]) && (sum_ext[MSB] != opa_q[MSB]);
         end
         OP_SUB: begin
            alu_res = dif_ext[MSB:0];
            alu_c   = dif_ext[DATA_W];
            alu_v   = (opa_q[MSB] != opb_q[MSB]) && (dif_ext[MSB] != opa_q[MSB]);
         end
         OP_AND:  alu_res = opa_q & opb_q;
         OP_OR:   alu_res = opa_q | opb_q;
         OP_XOR:  alu_res = opa_q ^ opb_q;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(opa_q) < $signed(opb_q))};
         OP_SLL:  alu_res = opa_q << opb_q[SH_W-1:0];
         OP_SRL:  alu_res = opa_q >> opb_q[SH_W-1:0];
      endcase
   end

   // Register file: host preload in IDLE, command writeback in WRITE.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: the register file is cleared on reset because its contents
         // are architecturally defined as zero afterwards; a plain storage
         // array with no such requirement would be left unreset.
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else if (host_wr) begin
         if (!(ZERO_R0 && host_addr == '0)) begin
            regs_q[host_addr] <= host_wd;
         end
      end else if (state_q == S_WRITE) begin
         if (!(ZERO_R0 && rd_q == '0)) begin
            regs_q[rd_q] <= result_q;
         end
      end
   end

   // Command FSM: IDLE -> EXEC -> WRITE -> IDLE with registered outputs.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         op_q     <= OP_ADD;
         rd_q     <= '0;
         opa_q    <= '0;
         opb_q    <= '0;
         result_q <= '0;
         flag_z_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         // NOTE: state uses non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  op_q    <= op_e'(cmd_op);
                  rd_q    <= cmd_rd;
                  opa_q   <= rs1_data;
                  opb_q   <= rs2_data;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               result_q <= alu_res;
               flag_z_q <= (alu_res == '0);
               flag_c_q <= alu_c;
               flag_v_q <= alu_v;
               done_q   <= 1'b1;
               state_q  <= S_WRITE;
            end
            S_WRITE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign done   = done_q;
   assign result = result_q;
   assign flag_z = flag_z_q;
   assign flag_c = flag_c_q;
   assign flag_v = flag_v_q;

endmodule

// File: doc/regfile_alu_engine.md
Name: regfile_alu_engine

Overview:
- Parametrised register-file/ALU execution engine.
- Accepts one register-to-register command per valid/ready handshake: reads two source registers, executes an 8-op ALU, writes the result back, and reports result plus flags.
- A host write port preloads registers, and two asynchronous debug read ports expose register contents.
- Successor to the fixed 32x32 register file and 2-bit ALU pairing, with a 3-cycle command FSM added.

Parameters:
- DATA_W, 32, register and ALU width in bits (>=8, power of 2).
- NREG, 32, number of registers (power of 2); ADDR_W = log2(NREG).
- ZERO_R0, 1, when 1 register 0 reads as 0 and ignores all writes.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine can accept a command.
- cmd_op  input  3  ALU opcode.
- cmd_rs1  input  ADDR_W  source A register.
- cmd_rs2  input  ADDR_W  source B register.
- cmd_rd  input  ADDR_W  destination register.
- host_we  input  1  host register write enable.
- host_addr  input  ADDR_W  host write address.
- host_wd  input  DATA_W  host write data.
- A1  input  ADDR_W  debug read address 1.
- A2  input  ADDR_W  debug read address 2.
- RD1  output  DATA_W  debug read data 1 (combinational).
- RD2  output  DATA_W  debug read data 2 (combinational).
- done  output  1  one-cycle pulse when the result is written.
- result  output  DATA_W  last ALU result; held until the next done.
- flag_z  output  1  result == 0.
- flag_c  output  1  carry / not-borrow.
- flag_v  output  1  signed overflow.

Behaviour:
- Reset (async, RST_N=0): all registers 0, state IDLE, done=0, result=0, all flags 0. A command in flight is discarded with no writeback.
- FSM states: IDLE -> EXEC -> WRITE -> IDLE.
- IDLE:
  - cmd_ready = !host_we (combinational). cmd_ready is 0 in EXEC and WRITE.
  - Accept on cmd_valid && cmd_ready at a rising edge: latch op and rd, latch operands opA=reg[rs1] and opB=reg[rs2] (pre-edge contents), go to EXEC.
  - host_we in IDLE writes reg[host_addr]=host_wd at the edge. If host_we and cmd_valid are both high, only the host write happens; the command waits.
- host_we outside IDLE is ignored (no write).
- EXEC: compute ALU(opA, opB) into internal registers; go to WRITE.
- WRITE:
  - reg[rd] = res, unless ZERO_R0 && rd==0.
  - result and flags update; done=1 for exactly this cycle; go to IDLE.
- Latency: done is high 2 cycles after the accept edge. Next accept is possible in the cycle after done, so peak throughput is 1 command per 3 cycles.
- ALU operations (all arithmetic modulo 2^DATA_W):
  - 000 ADD a+b.
  - 001 SUB a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLT: 1 if signed a<b, else 0.
  - 110 SLL: a << b[log2(DATA_W)-1:0].
  - 111 SRL: logical a >> b[log2(DATA_W)-1:0].
- Flags:
  - flag_z = (res==0) for all ops.
  - flag_c: ADD carry-out; SUB carry-out of a+~b+1 (1 when a>=b unsigned); 0 otherwise.
  - flag_v: signed overflow for ADD/SUB; 0 otherwise.
- Debug reads: RD1=reg[A1], RD2=reg[A2], asynchronous; r0 reads 0 when ZERO_R0.
- Writes become visible on RD1/RD2 after the writing edge; there is no write-through bypass.
- A command whose rs equals the previous command's rd reads the updated value, because writeback precedes the next accept.

Test Plan:
- Reset: assert RST_N=0 mid-EXEC of an ADD into r5 -> done never pulses, r5=0, result=0, flags=0, cmd_ready=1 after release.
- ADD wrap: host writes r1=0xFFFFFFFF, r2=0x00000001; ADD rd=r3 -> done 2 cycles after accept, r3=0, result=0, flag_z=1, flag_c=1, flag_v=0.
- Signed overflow: r1=0x7FFFFFFF, r2=1, ADD -> result=0x80000000, flag_v=1, flag_c=0. Then SUB r2-r1 -> 0x80000002, flag_c=0.
- SLT/shift: r1=0xFFFFFFFE (-2), r2=3; SLT -> 1; SRL r1>>r2 -> 0x1FFFFFFF; SLL with r2=35 -> shift by 3 -> 0xFFFFFFF0.
- r0 protection: host write r0=0x55 and ADD rd=r0 -> RD1(A1=0)=0 throughout; done still pulses with result correct.
- Contention: host_we=1 and cmd_valid=1 in IDLE -> cmd_ready=0, host write lands, command accepted next cycle. host_we during EXEC -> register unchanged.
